// File: rtl/enc_4to2.sv
// Registered 4-to-2 priority encoder (a > b > c > d) with valid/err flags
// and a saturating count of multi-hot samples.
module enc_4to2 #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             e1,
    output logic             e0,
    output logic             valid,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt
);

    logic [2:0] ones;
    logic       any_hi;
    logic       multi_hi;
    logic [1:0] code_nxt;

    always_comb begin
        ones     = 3'(a) + 3'(b) + 3'(c) + 3'(d);
        any_hi   = (ones != 3'd0);
        multi_hi = (ones > 3'd1);
        // All-low keeps the previously registered code
        code_nxt = {e1, e0};
        if (a)
            code_nxt = 2'b11;
        else if (b)
            code_nxt = 2'b10;
        else if (c)
            code_nxt = 2'b01;
        else if (d)
            code_nxt = 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e1      <= 1'b0;
            e0      <= 1'b0;
            valid   <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            {e1, e0} <= code_nxt;
            valid    <= any_hi;
            err      <= multi_hi;
            if (multi_hi && (err_cnt != {CNT_W{1'b1}}))
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_enc_4to2.sv
// Self-checking bench for enc_4to2: literal scenarios plus a behavioural
// model driven by exhaustive and random stimulus.
module tb_enc_4to2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic       e1, e0, valid, err;
    logic [7:0] err_cnt;
    logic       e1_s, e0_s, valid_s, err_s;
    logic [1:0] err_cnt_s;

    int passed = 0;
    int total  = 0;

    int m_code, m_valid, m_err, m_cnt8, m_cnt2;

    enc_4to2 dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .e1(e1), .e0(e0), .valid(valid), .err(err), .err_cnt(err_cnt)
    );

    enc_4to2 #(.CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .e1(e1_s), .e0(e0_s), .valid(valid_s), .err(err_s),
        .err_cnt(err_cnt_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp)
            passed++;
        else
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_code = 0; m_valid = 0; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
    endtask

    // Model: popcount and highest set line decide everything
    task automatic model_sample(input logic [3:0] v);
        int n;
        n = $countones(v);
        for (int i = 3; i >= 0; i--) begin
            if (v[i]) begin
                m_code = i;
                break;
            end
        end
        m_valid = (n > 0) ? 1 : 0;
        m_err   = (n > 1) ? 1 : 0;
        if (m_err == 1) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".code"}, int'({e1, e0}), m_code);
        chk({tag, ".valid"}, int'(valid), m_valid);
        chk({tag, ".err"}, int'(err), m_err);
        chk({tag, ".cnt"}, int'(err_cnt), m_cnt8);
        chk({tag, ".code_s"}, int'({e1_s, e0_s}), m_code);
        chk({tag, ".cnt_s"}, int'(err_cnt_s), m_cnt2);
    endtask

    task automatic step(input logic [3:0] v, input string tag);
        {a, b, c, d} = v;
        @(posedge clk);
        #1;
        model_sample(v);
        check_model(tag);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".code"}, int'({e1, e0}), 0);
        chk({tag, ".valid"}, int'(valid), 0);
        chk({tag, ".err"}, int'(err), 0);
        chk({tag, ".cnt"}, int'(err_cnt), 0);
        chk({tag, ".cnt_s"}, int'(err_cnt_s), 0);
    endtask

    initial begin
        logic [3:0] v;
        model_reset();
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // One-hot sweep with literal expectations
        step(4'b0001, "d_only");
        chk("d_only.lit", int'({e1, e0, valid, err}), 4'b0010);
        step(4'b0010, "c_only");
        chk("c_only.lit", int'({e1, e0}), 1);
        step(4'b0010, "c_hold");
        step(4'b0100, "b_only");
        chk("b_only.lit", int'({e1, e0}), 2);
        step(4'b1000, "a_only");
        chk("a_only.lit", int'({e1, e0}), 3);

        // Priority and error count
        step(4'b1001, "a_d");
        chk("a_d.lit", int'({e1, e0, err}), 3'b111);
        chk("a_d.cnt_lit", int'(err_cnt), 1);
        step(4'b0110, "b_c");
        chk("b_c.lit", int'({e1, e0, err}), 3'b101);
        chk("b_c.cnt_lit", int'(err_cnt), 2);
        step(4'b0100, "b_single");
        step(4'b0000, "all_low");
        chk("all_low.lit", int'({e1, e0, valid, err}), 4'b1000);
        chk("all_low.cnt_lit", int'(err_cnt), 2);

        // Asynchronous reset between edges
        step(4'b1000, "pre_rst");
        chk("pre_rst.lit", int'({e1, e0, valid}), 3'b111);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_zero("async_rst");
        {a, b, c, d} = 4'b1111;
        repeat (2) begin
            @(negedge clk);
            chk_zero("in_rst");
        end
        {a, b, c, d} = 4'b0000;
        rst_n = 1'b1;
        step(4'b0000, "post_rst");
        chk("post_rst.lit", int'({e1, e0, valid}), 0);

        // Saturation of the 2-bit counter
        chk("sat.start", int'(err_cnt_s), 0);
        step(4'b1100, "sat1");
        chk("sat1.lit", int'(err_cnt_s), 1);
        step(4'b0011, "sat2");
        chk("sat2.lit", int'(err_cnt_s), 2);
        step(4'b1010, "sat3");
        chk("sat3.lit", int'(err_cnt_s), 3);
        step(4'b0101, "sat4");
        chk("sat4.lit", int'(err_cnt_s), 3);
        step(4'b1111, "sat5");
        chk("sat5.lit", int'(err_cnt_s), 3);
        chk("sat5.cnt8", int'(err_cnt), 5);

        // Exhaustive 16 combinations, then from all-low in between
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            step(v, "exh");
        end
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            step(4'b0000, "exh_low");
            step(v, "exh2");
        end

        // Random stimulus, long enough to saturate the 8-bit counter
        for (int i = 0; i < 700; i++) begin
            v = 4'($urandom_range(0, 15));
            step(v, "rand");
        end

        // Random with occasional mid-cycle resets
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                model_reset();
                chk_zero("rand_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
            v = 4'($urandom_range(0, 15));
            step(v, "rand2");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
